// File: rtl/poola1_cu.sv
// Control unit for the 2x2 stride-2 pooling stage behind the first convolution.
// Optional feature macro: POOLA1_LAYER_DONE_EN (adds the per-layer map counter and layer_done).
module poola1_cu #(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 28,
  parameter int IFM_DEPTH             = 6,
  parameter int WRITE_DELAY           = 2,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  input  logic                             end_from_next,
  output logic                             end_to_previous,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             ifm_sel_current,
  output logic                             pool_first,
  output logic                             pool_enable,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             ifm_sel_next,
  output logic                             start_to_next,
  output logic                             ready,
`ifdef POOLA1_LAYER_DONE_EN
  output logic                             layer_done,
`endif
  output logic [1:0]                       dbg_state
);

  // Handshake: upstream pulses start_from_previous only while end_to_previous is
  // high; downstream accepts a map while end_from_next is high, and start_to_next
  // is asserted for exactly the one cycle in which that acceptance happens.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_DRAIN   = 2'd2,
    S_HANDOFF = 2'd3
  } state_t;

  localparam int CW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IFM_SIZE_NEXT - 1);
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] WR_LAST =
    ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  localparam logic [31:0] IFM_W = 32'(IFM_SIZE);

  if ((IFM_SIZE % 2) != 0 || IFM_SIZE < 2 || WRITE_DELAY < 1 ||
      IFM_DEPTH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("poola1_cu: invalid parameter set");
  end

  state_t                           state_q;
  logic                             rd_en_q;
  logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_q;
  logic                             dx_q, dy_q;
  logic [CW-1:0]                    c_q, r_q;
  logic                             sel_cur_q, sel_next_q;
  logic                             pool_first_q, pool_enable_q;
  logic [WRITE_DELAY-1:0]           wr_sr_q;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q;

  logic                             dx_d, dy_d;
  logic [CW-1:0]                    c_d, r_d;
  logic [31:0]                      addr_full;
  logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_d;
  logic                             last_elem;
  logic                             win_done;
  logic                             wr_en;
  logic                             wr_last;

  // Window walk: dx fastest, then dy, then column c, then row r.
  always_comb begin
    dx_d = ~dx_q;
    dy_d = dy_q;
    c_d  = c_q;
    r_d  = r_q;
    if (dx_q) begin
      dy_d = ~dy_q;
      if (dy_q) begin
        if (c_q == C_LAST) begin
          c_d = '0;
          r_d = (r_q == C_LAST) ? '0 : r_q + CW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
    end
    addr_full = (((32'(r_d) << 1) + 32'(dy_d)) * IFM_W) + (32'(c_d) << 1) + 32'(dx_d);
    rd_addr_d = addr_full[ADDRESS_SIZE_IFM-1:0];
    last_elem = dx_q & dy_q & (c_q == C_LAST) & (r_q == C_LAST);
    win_done  = rd_en_q & dx_q & dy_q;
    wr_en     = wr_sr_q[WRITE_DELAY-1];
    wr_last   = wr_en & (wr_addr_q == WR_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      dx_q          <= 1'b0;
      dy_q          <= 1'b0;
      c_q           <= '0;
      r_q           <= '0;
      sel_cur_q     <= 1'b0;
      sel_next_q    <= 1'b0;
      pool_first_q  <= 1'b0;
      pool_enable_q <= 1'b0;
      wr_sr_q       <= '0;
      wr_addr_q     <= '0;
    end else begin
      pool_enable_q <= rd_en_q;
      pool_first_q  <= rd_en_q & ~dx_q & ~dy_q;
      wr_sr_q       <= (wr_sr_q << 1) | WRITE_DELAY'(win_done);
      if (wr_en) begin
        wr_addr_q <= wr_last ? '0 : wr_addr_q + ADDRESS_SIZE_NEXT_IFM'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start_from_previous) begin
            state_q   <= S_READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
            c_q       <= '0;
            r_q       <= '0;
          end
        end
        S_READ: begin
          if (last_elem) begin
            state_q   <= S_DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
            c_q       <= '0;
            r_q       <= '0;
            sel_cur_q <= ~sel_cur_q;
          end else begin
            rd_addr_q <= rd_addr_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            c_q       <= c_d;
            r_q       <= r_d;
          end
        end
        // Writes trail reads by WRITE_DELAY; wait for the one that wraps the address.
        S_DRAIN: begin
          if (wr_last) begin
            state_q <= S_HANDOFF;
          end
        end
        S_HANDOFF: begin
          if (end_from_next) begin
            state_q    <= S_IDLE;
            sel_next_q <= ~sel_next_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign end_to_previous          = (state_q == S_IDLE);
  assign ready                    = end_to_previous;
  assign start_to_next            = (state_q == S_HANDOFF) & end_from_next;
  assign ifm_enable_read_current  = rd_en_q;
  assign ifm_address_read_current = rd_addr_q;
  assign ifm_sel_current          = sel_cur_q;
  assign pool_first               = pool_first_q;
  assign pool_enable              = pool_enable_q;
  assign ifm_enable_write_next    = wr_en;
  assign ifm_address_write_next   = wr_addr_q;
  assign ifm_sel_next             = sel_next_q;
  assign dbg_state                = state_q;

`ifdef POOLA1_LAYER_DONE_EN
  localparam int MW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam logic [MW-1:0] M_LAST = MW'(IFM_DEPTH - 1);

  logic [MW-1:0] map_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_cnt_q <= '0;
    end else if (start_to_next) begin
      map_cnt_q <= (map_cnt_q == M_LAST) ? '0 : map_cnt_q + MW'(1);
    end
  end

  assign layer_done = start_to_next & (map_cnt_q == M_LAST);
`endif

endmodule

// File: doc/poola1_cu.md
# poola1_cu

Control unit for the 2x2 stride-2 pooling stage that directly consumes the feature maps produced by the first convolution stage. Each handshake covers one IFM_SIZE x IFM_SIZE map. For each map, the unit:
- reads the map from the upstream ping-pong memory in window order;
- drives accumulate/compare strobes to the pooling datapath;
- writes the IFM_SIZE/2 x IFM_SIZE/2 result into its own ping-pong memory;
- hands the result to the next stage with the same start/end handshake used across the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (unused by control, kept for uniform instantiation)
- IFM_SIZE, 28, input map side; must be even
- IFM_DEPTH, 6, maps per layer
- WRITE_DELAY, 2, cycles from the 4th read enable of a window to its write enable (memory read latency 1 + datapath 1)
- IFM_SIZE_NEXT, IFM_SIZE/2, output map side
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE)
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_from_previous  in  1  one-cycle pulse: the upstream bank is full
- end_from_next  in  1  level: the next stage is idle and accepts a map
- end_to_previous  out  1  level: this unit is idle and can accept a map
- ifm_enable_read_current  out  1  upstream memory read enable
- ifm_address_read_current  out  ADDRESS_SIZE_IFM  upstream read address
- ifm_sel_current  out  1  upstream bank being read
- pool_first  out  1  data on the bus is element 0 of a window (load)
- pool_enable  out  1  data on the bus is valid (accumulate/compare)
- ifm_enable_write_next  out  1  write enable into the next memory
- ifm_address_write_next  out  ADDRESS_SIZE_NEXT_IFM  write address
- ifm_sel_next  out  1  next-memory bank being written
- start_to_next  out  1  one-cycle pulse: the output map is complete
- ready  out  1  identical to end_to_previous

## Operation
- The main FSM has four states: IDLE, READ, DRAIN and HANDOFF.
- IDLE:
  - end_to_previous = ready = 1.
  - When start_from_previous is sampled high, go to READ.
- READ:
  - ifm_enable_read_current = 1 every cycle, with no bubbles.
  - The window counters are dx, dy (1 bit each), c and r (0..IFM_SIZE_NEXT-1).
  - Read address = (2r+dy)*IFM_SIZE + 2c + dx.
  - Element order within a window is (dy,dx) = (0,0), (0,1), (1,0), (1,1). Windows advance c first, then r.
  - After the read of window (IFM_SIZE_NEXT-1, IFM_SIZE_NEXT-1) element (1,1), go to DRAIN and toggle ifm_sel_current.
- DRAIN:
  - Wait until the last write of the map has issued, then go to HANDOFF.
- HANDOFF:
  - When end_from_next = 1: pulse start_to_next for one cycle, toggle ifm_sel_next, and go to IDLE.
- start_from_previous is ignored outside IDLE. Upstream only pulses it while end_to_previous = 1.
- pool_enable is ifm_enable_read_current delayed by 1 cycle.
- pool_first is (read enable and dx=0 and dy=0) delayed by 1 cycle.
- ifm_enable_write_next is (read enable and dx=1 and dy=1) delayed by WRITE_DELAY cycles, using a shift register.
- ifm_address_write_next increments after each write. It wraps from IFM_SIZE_NEXT^2-1 to 0 on the final write of a map; that final write is the DRAIN exit condition.

## Timing
- Reset values:
  - state = IDLE, so end_to_previous = ready = 1.
  - All other outputs = 0. This includes both sel bits, both address counters and the delay lines.
- Cycle numbering for one map: the start pulse is sampled at edge 0. READ then spans cycles 1..IFM_SIZE^2.
- Windows and writes:
  - The 4th read of window k is at cycle 4k+4.
  - The write for window k is at cycle 4k+4+WRITE_DELAY.
- The last write is at cycle IFM_SIZE^2+WRITE_DELAY. DRAIN exits on that edge.
- Earliest start_to_next is the cycle after DRAIN exits, if end_from_next is already high.
- Reset mid-map: all outputs return to their reset values immediately. Writes still in the delay line are discarded.
- end_from_next held low: HANDOFF waits indefinitely, and end_to_previous stays 0. This backpressures upstream.

## Configuration
- POOLA1_LAYER_DONE_EN defined:
  - Adds a map counter, 0..IFM_DEPTH-1, that increments on each start_to_next.
  - Adds an output layer_done (1 bit). It pulses together with the start_to_next of map IFM_DEPTH-1, and the counter then wraps to 0.
  - layer_done and the counter reset to 0.
- POOLA1_LAYER_DONE_EN undefined: the counter and the layer_done port are absent, and all other behaviour is identical.

## Test plan
All scenarios use IFM_SIZE=28 and WRITE_DELAY=2.
- After reset, check the outputs without any stimulus -> ready=1, all other outputs 0.
- Pulse start with end_from_next=1 -> read addresses in cycles 1..8 are 0, 1, 28, 29, 2, 3, 30, 31. pool_first in cycles 2 and 6. First write (address 0) in cycle 6.
- Full map -> 784 read cycles, the last at address 783. 196 writes, the last at address 195 in cycle 786. Address then wraps to 0. start_to_next pulses in cycle 787, and ifm_sel_current and ifm_sel_next are both 1.
- Hold end_from_next=0 at the end of a map -> stays in HANDOFF with ready=0. Raise end_from_next -> start_to_next pulses the next cycle, then ready=1.
- Assert reset at READ cycle 300 -> all outputs return to their reset values. The next start restarts from address 0 with both sel bits = 0.
- POOLA1_LAYER_DONE_EN, 6 consecutive maps -> layer_done pulses only together with the 6th start_to_next.
